// File: rtl/my_pkg.sv
// Shared types for the execute issue path: unit select, shadow pipe
// entry, issue controller states and a saturating add helper.
package my_pkg;

    typedef enum logic [1:0] {
        XU_ALU = 2'd0,
        XU_MUL = 2'd1,
        XU_MEM = 2'd2,
        XU_BR  = 2'd3
    } xu;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_mem;
        logic       kill;
    } issue_entry_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MEM   = 2'd1,
        FLUSH = 2'd2
    } ctrl_state_t;

    function automatic logic [31:0] reg_bit(input logic [4:0] r);
        return (r == 5'd0) ? 32'd0 : (32'd1 << r);
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hffff_ffff : s[31:0];
    endfunction

endpackage

// File: rtl/exec_issue_ctrl_scoreboard.sv
// Register busy scoreboard: one bit per architectural register,
// set wins over clear, x0 never busy.
module exec_scoreboard
    import my_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        set_en,
    input  logic [4:0]  set_rd,
    input  logic [31:0] clr_mask,
    output logic [31:0] busy
);

    logic [31:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q & ~clr_mask;
        if (set_en) busy_d = busy_d | reg_bit(set_rd);
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign busy = busy_q;

endmodule

// File: rtl/exec_issue_ctrl.sv
// Issue controller in front of the execute pipe: RAW blocking, single
// memory op in flight, stream tag and branch kill. EXEC_ISSUE_STATS_EN adds counters.
module exec_issue_ctrl
    import my_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  xu           in_xu,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [3:0]  in_tag,
    output logic        issue_valid,
    output xu           issue_xu,
    output logic [3:0]  issue_tag,
    input  logic        jump_in,
    output logic        retire_we,
    output logic [4:0]  retire_rd,
    output logic [3:0]  cur_tag,
    output logic        flush
`ifdef EXEC_ISSUE_STATS_EN
    ,
    output logic [31:0] stat_issued,
    output logic [31:0] stat_stall,
    output logic [31:0] stat_killed
`endif
);

    issue_entry_t [DEPTH:0] pipe_q, pipe_d;
    ctrl_state_t            state_q, state_d;
    logic [3:0]             cur_tag_q, cur_tag_d;
    logic                   flush_q, flush_d;

    logic [31:0]  busy;
    logic [31:0]  clr_mask;
    logic [31:0]  kill_mask;
    logic         set_en;
    logic         discard, hazard, in_is_mem, can_issue;
    issue_entry_t ret;

    assign ret       = pipe_q[DEPTH];
    assign in_is_mem = (in_xu == XU_MEM);
    assign discard   = in_valid && (in_tag != cur_tag_q);
    assign hazard    = busy[in_rs1] || busy[in_rs2];

    assign can_issue = !reset && in_valid && !discard && !hazard
                    && !jump_in && (state_q != FLUSH)
                    && !(in_is_mem && state_q == MEM);

    assign in_ready    = !reset && !jump_in && (discard || can_issue);
    assign issue_valid = can_issue;
    assign issue_xu    = can_issue ? in_xu : XU_ALU;
    assign issue_tag   = can_issue ? cur_tag_q : 4'd0;
    assign retire_we   = !reset && ret.valid && !ret.kill && (ret.rd != 5'd0);
    assign retire_rd   = (!reset && ret.valid) ? ret.rd : 5'd0;
    assign cur_tag     = cur_tag_q;
    assign flush       = flush_q;

    // Shift the shadow pipe; a taken branch at the tail kills everything behind it.
    always_comb begin
        kill_mask        = '0;
        pipe_d[0].valid  = can_issue;
        pipe_d[0].rd     = in_rd;
        pipe_d[0].is_mem = in_is_mem;
        pipe_d[0].kill   = 1'b0;
        for (int i = 1; i <= DEPTH; i++) pipe_d[i] = pipe_q[i-1];
        if (jump_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pipe_q[i].valid) begin
                    pipe_d[i+1].kill = 1'b1;
                    if (!pipe_q[i].kill) kill_mask = kill_mask | reg_bit(pipe_q[i].rd);
                end
            end
        end
        clr_mask = kill_mask;
        if (ret.valid && !ret.kill) clr_mask = clr_mask | reg_bit(ret.rd);
        set_en = can_issue && (in_rd != 5'd0);
    end

    always_comb begin
        state_d   = state_q;
        cur_tag_d = jump_in ? cur_tag_q + 4'd1 : cur_tag_q;
        unique case (state_q)
            RUN: begin
                if (jump_in)                     state_d = FLUSH;
                else if (can_issue && in_is_mem) state_d = MEM;
            end
            MEM: begin
                if (jump_in)                                 state_d = FLUSH;
                else if (ret.valid && ret.is_mem && !ret.kill) state_d = RUN;
            end
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
        flush_d = (state_d == FLUSH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_q    <= '0;
            state_q   <= RUN;
            cur_tag_q <= 4'd0;
            flush_q   <= 1'b0;
        end else begin
            pipe_q    <= pipe_d;
            state_q   <= state_d;
            cur_tag_q <= cur_tag_d;
            flush_q   <= flush_d;
        end
    end

    exec_scoreboard u_sb (
        .clk      (clk),
        .reset    (reset),
        .set_en   (set_en),
        .set_rd   (in_rd),
        .clr_mask (clr_mask),
        .busy     (busy)
    );

`ifdef EXEC_ISSUE_STATS_EN
    logic [31:0] stat_issued_q, stat_issued_d;
    logic [31:0] stat_stall_q, stat_stall_d;
    logic [31:0] stat_killed_q, stat_killed_d;
    logic [31:0] kill_cnt;

    always_comb begin
        kill_cnt = '0;
        if (jump_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pipe_q[i].valid && !pipe_q[i].kill) kill_cnt = kill_cnt + 32'd1;
            end
        end
        stat_issued_d = sat_add(stat_issued_q, {31'd0, can_issue});
        stat_stall_d  = sat_add(stat_stall_q, {31'd0, in_valid && !in_ready && !reset});
        stat_killed_d = sat_add(stat_killed_q, kill_cnt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
            stat_killed_q <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_stall_q  <= stat_stall_d;
            stat_killed_q <= stat_killed_d;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
    assign stat_killed = stat_killed_q;
`endif

endmodule
